// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, pipelined imem req/gnt/rvalid, in-order buffer to decode
// Optional FETCH_ILLEGAL_CHK_EN: flags non-32-bit encodings (instr[1:0] != 11) and replaces them with NOP.
module fetch_stage #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
`ifdef FETCH_ILLEGAL_CHK_EN
   ,
   output logic        if_illegal
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = ((CW > OW) ? CW : OW) + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [OW-1:0] r_out;
   logic [OW-1:0] r_drop;
   logic [CW-1:0] r_wptr;
   logic [CW-1:0] r_rptr;
   logic [31:0]   r_mem_instr [FIFO_DEPTH];
   logic [31:0]   r_mem_pc    [FIFO_DEPTH];
`ifdef FETCH_ILLEGAL_CHK_EN
   logic          r_mem_ill   [FIFO_DEPTH];
`endif

   logic          w_rv_eff;
   logic          w_grant;
   logic          w_drop;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [SW-1:0] w_sum;
   logic [OW-1:0] w_drop_new;
   logic [31:0]   w_redir_pc;

   // A response with nothing outstanding is a leftover from before reset and is ignored.
   assign w_rv_eff   = imem_rvalid && (r_out != '0);
   assign w_grant    = imem_req && imem_gnt;
   assign w_drop     = w_rv_eff && (r_drop != '0);
   assign w_push     = w_rv_eff && (r_drop == '0) && !redirect;
   assign w_pop      = if_valid && if_ready;
   assign w_count    = r_wptr - r_rptr;
   assign w_empty    = (w_count == '0);
   assign w_sum      = SW'(r_out) + SW'(w_count);
   assign w_drop_new = r_out - OW'(w_rv_eff);
   assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
   assign imem_addr  = r_fetch_pc;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_BOOT;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      imem_req     = 1'b0;
      case (r_state)
         ST_BOOT:  w_next_state = ST_RUN;
         ST_RUN:   imem_req = (r_out < OW'(MAX_OUTSTANDING)) && (w_sum < SW'(FIFO_DEPTH));
         ST_DRAIN: begin
            if ((r_drop == '0) || (w_rv_eff && (r_drop == OW'(1))))
               w_next_state = ST_RUN;
         end
         default:  w_next_state = ST_BOOT;
      endcase
      if (redirect) begin
         imem_req     = 1'b0;
         w_next_state = (w_drop_new != '0) ? ST_DRAIN : ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_out      <= '0;
         r_drop     <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else if (redirect) begin
         // Everything still in flight belongs to the abandoned path.
         r_fetch_pc <= w_redir_pc;
         r_resp_pc  <= w_redir_pc;
         r_out      <= w_drop_new;
         r_drop     <= w_drop_new;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
         r_out <= r_out + OW'(w_grant) - OW'(w_rv_eff);
         if (w_drop) r_drop <= r_drop - OW'(1);
         if (w_push) begin
            r_mem_instr[r_wptr[AW-1:0]] <= imem_rdata;
            r_mem_pc[r_wptr[AW-1:0]]    <= r_resp_pc;
`ifdef FETCH_ILLEGAL_CHK_EN
            r_mem_ill[r_wptr[AW-1:0]]   <= (imem_rdata[1:0] != 2'b11);
`endif
            r_wptr    <= r_wptr + CW'(1);
            r_resp_pc <= r_resp_pc + 32'd4;
         end
         if (w_pop) r_rptr <= r_rptr + CW'(1);
      end
   end

   always_comb begin
      if_valid = !w_empty && !redirect;
      if_instr = NOP;
      if_pc    = 32'h0;
`ifdef FETCH_ILLEGAL_CHK_EN
      if_illegal = 1'b0;
`endif
      if (if_valid) begin
         if_instr = r_mem_instr[r_rptr[AW-1:0]];
         if_pc    = r_mem_pc[r_rptr[AW-1:0]];
`ifdef FETCH_ILLEGAL_CHK_EN
         if (r_mem_ill[r_rptr[AW-1:0]]) begin
            if_illegal = 1'b1;
            if_instr   = NOP;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a program-order/epoch reference model
// Honours FETCH_ILLEGAL_CHK_EN when the design is built with it.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef FETCH_ILLEGAL_CHK_EN
   logic        if_illegal;
`endif

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_ILLEGAL_CHK_EN
      , .if_illegal(if_illegal)
`endif
   );

   typedef struct { logic [31:0] addr; int ep; int cyc; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;

   req_t mq[$];            // granted requests awaiting a response, in order
   ent_t mf[$];            // words decode should still receive, in program order
   logic [31:0] xlog_pc[$];
   logic [31:0] xlog_instr[$];
   int          xlog_cyc[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0, epoch = 0, max_out = 0, reset_cyc = 0, first_req_cyc = -1;
   int knob_rsp = 1, knob_gnt = 1, knob_rdy = 1;
   logic boot;
   logic [31:0] exp_fetch;
   logic last_req, last_valid;
   logic [31:0] last_addr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      if (a == 32'h300) return 32'h0000_0000;
      if (a == 32'h304) return 32'h0000_0033;
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] exp_instr(input logic [31:0] w);
`ifdef FETCH_ILLEGAL_CHK_EN
      return (w[1:0] != 2'b11) ? NOP : w;
`else
      return w;
`endif
   endfunction

   function automatic logic knob_bit(input int k);
      if (k == 1) return 1'b1;
      if (k == 2) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   task automatic do_reset();
      reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      mq.delete(); mf.delete();
      exp_fetch = RST_PC; boot = 1'b1; reset_cyc = cyc; first_req_cyc = -1;
   endtask

   // One clock cycle: drive, check against the model, then advance the model over the edge.
   task automatic step(input logic redir, input logic [31:0] tgt, input logic stray);
      logic rv, g, rdy, exp_req, exp_valid;
      logic [31:0] rd;
      int stale;
      req_t r;
      ent_t e;
      rv = 1'b0; rd = 32'h0;
      if (mq.size() > 0 && mq[0].cyc < cyc) rv = knob_bit(knob_rsp);
      if (rv) rd = word(mq[0].addr);
      if (stray && mq.size() == 0) begin rv = 1'b1; rd = 32'hDEAD_BEEF; end
      g   = knob_bit(knob_gnt);
      rdy = knob_bit(knob_rdy);
      imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
      redirect = redir; redirect_pc = tgt; if_ready = rdy;
      #1;
      stale = 0;
      foreach (mq[i]) if (mq[i].ep != epoch) stale++;
      exp_req = !boot && !redir && stale == 0 && mq.size() < 2 && (mq.size() + mf.size()) < 4;
      check_eq("imem_req", imem_req, exp_req);
      check_eq("imem_addr", imem_addr, exp_fetch);
      exp_valid = (mf.size() > 0) && !redir;
      check_eq("if_valid", if_valid, exp_valid);
      if (exp_valid) begin
         check_eq("if_pc", if_pc, mf[0].pc);
         check_eq("if_instr", if_instr, exp_instr(mf[0].w));
      end else if (mf.size() == 0) begin
         check_eq("if_pc_empty", if_pc, 32'h0);
         check_eq("if_instr_empty", if_instr, NOP);
      end
`ifdef FETCH_ILLEGAL_CHK_EN
      if (exp_valid) check_eq("if_illegal", if_illegal, mf[0].w[1:0] != 2'b11);
      else if (mf.size() == 0) check_eq("if_illegal_empty", if_illegal, 0);
`endif
      last_req = imem_req; last_addr = imem_addr; last_valid = if_valid;
      if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (redir) begin
         mf.delete();
         if (rv && mq.size() > 0) void'(mq.pop_front());
         epoch++;
         exp_fetch = tgt & 32'hFFFF_FFFC;
      end else begin
         if (exp_valid && rdy) begin
            xlog_pc.push_back(if_pc); xlog_instr.push_back(if_instr); xlog_cyc.push_back(cyc);
            void'(mf.pop_front());
         end
         if (rv && mq.size() > 0) begin
            r = mq.pop_front();
            if (r.ep == epoch) begin e.pc = r.addr; e.w = word(r.addr); mf.push_back(e); end
         end
         if (imem_req && g) begin
            r.addr = exp_fetch; r.ep = epoch; r.cyc = cyc;
            mq.push_back(r);
            exp_fetch = exp_fetch + 32'd4;
         end
      end
      if (mq.size() > max_out) max_out = mq.size();
      boot = 1'b0;
      cyc++;
      @(posedge clk); #1;
   endtask

   initial begin
      int n0, mark, rcyc, found;
      do_reset();

      // Reset release and first stream.
      knob_gnt = 1; knob_rsp = 1; knob_rdy = 1;
      repeat (8) step(1'b0, 32'h0, 1'b0);
      check_eq("first_req_cycle", first_req_cyc - reset_cyc, 1);
      if (xlog_pc.size() >= 3) begin
         check_eq("first_valid_cycle", xlog_cyc[0] - reset_cyc, 3);
         check_eq("stream_pc0", xlog_pc[0], 32'h100);
         check_eq("stream_pc1", xlog_pc[1], 32'h104);
         check_eq("stream_pc2", xlog_pc[2], 32'h108);
         check_eq("stream_back_to_back", xlog_cyc[2] - xlog_cyc[0], 2);
      end else check_eq("stream_len", xlog_pc.size(), 3);

      // Decode stall fills the buffer and throttles requests.
      knob_rdy = 0;
      repeat (10) step(1'b0, 32'h0, 1'b0);
      check_eq("stall_req_low", last_req, 1'b0);
      knob_gnt = 0; knob_rdy = 1; n0 = xlog_pc.size();
      repeat (6) step(1'b0, 32'h0, 1'b0);
      check_eq("stall_buffered", xlog_pc.size() - n0, 4);
      knob_gnt = 1;
      repeat (6) step(1'b0, 32'h0, 1'b0);

      // Grant withheld: address must hold.
      do_reset();
      knob_gnt = 1; knob_rsp = 1; knob_rdy = 1;
      repeat (3) step(1'b0, 32'h0, 1'b0);
      knob_gnt = 0;
      repeat (3) begin
         step(1'b0, 32'h0, 1'b0);
         check_eq("gnt_hold_addr", last_addr, 32'h108);
         check_eq("gnt_hold_req", last_req, 1'b1);
      end
      knob_gnt = 1;
      repeat (6) step(1'b0, 32'h0, 1'b0);

      // Redirect with two requests in flight.
      knob_rsp = 0;
      repeat (4) step(1'b0, 32'h0, 1'b0);
      check_eq("pre_redirect_outstanding", mq.size(), 2);
      mark = xlog_pc.size(); rcyc = cyc;
      step(1'b1, 32'h200, 1'b0);
      knob_rsp = 1;
      repeat (10) step(1'b0, 32'h0, 1'b0);
      if (xlog_pc.size() > mark) begin
         check_eq("drain_first_pc", xlog_pc[mark], 32'h200);
         check_eq("drain_first_cycle", xlog_cyc[mark] - rcyc, 5);
      end else check_eq("drain_delivered", xlog_pc.size() - mark, 1);

      // Redirect coinciding with a response and a decode pop.
      knob_rdy = 0;
      repeat (3) step(1'b0, 32'h0, 1'b0);
      knob_rdy = 1;
      step(1'b1, 32'h283, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      check_eq("redir_pop_void", last_valid, 1'b0);
      repeat (8) step(1'b0, 32'h0, 1'b0);

      // Encodings with instr[1:0] != 11.
      n0 = xlog_pc.size();
      step(1'b1, 32'h300, 1'b0);
      repeat (12) step(1'b0, 32'h0, 1'b0);
      found = 0;
      for (int i = n0; i < xlog_pc.size(); i++) begin
         if (xlog_pc[i] == 32'h300) begin found++; check_eq("instr_at_300", xlog_instr[i], exp_instr(32'h0)); end
         if (xlog_pc[i] == 32'h304) begin found++; check_eq("instr_at_304", xlog_instr[i], 32'h33); end
      end
      check_eq("illegal_words_seen", found, 2);

      // Randomized traffic, with one mid-run reset followed by a stray response.
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) begin
            knob_rsp = $urandom_range(1, 2);
            knob_gnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2);
            knob_rdy = $urandom_range(0, 2);
         end
         if (i == 1500) begin
            do_reset();
            step(1'b0, 32'h0, 1'b1);
         end else if ($urandom_range(0, 39) == 0) begin
            step(1'b1, $urandom, 1'b0);
         end else begin
            step(1'b0, 32'h0, 1'b0);
         end
      end
      check_eq("max_outstanding_le2", max_out <= 2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
